// File: rtl/mcu_spi_pkg.sv
// Shared types and constants for the MCU SPI target front end.
package mcu_spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_TARGET  = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_HOLD    = 2'd3
  } spi_state_t;

  localparam logic [2:0] TGT_SYSCTRL = 3'd0;
  localparam logic [2:0] TGT_HID     = 3'd1;
  localparam logic [2:0] TGT_OSD     = 3'd2;
  localparam logic [2:0] TGT_SDC     = 3'd3;

endpackage

// File: rtl/mcu_spi_sync.sv
// N-stage synchronizer with one extra history flop and registered edge pulses.
module mcu_spi_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= '0;
      prev  <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      prev  <= chain[STAGES-1];
      rise  <= chain[STAGES-1] & ~prev;
      fall  <= ~chain[STAGES-1] & prev;
    end
  end

  assign level = chain[STAGES-1];

endmodule

// File: rtl/mcu_spi_target.sv
// SPI mode-0 target: first byte of a frame selects the target, later bytes are strobed out.
// Optional frame watchdog enabled by defining MCU_SPI_TIMEOUT_EN.
module mcu_spi_target
  import mcu_spi_pkg::*;
#(
  parameter int unsigned SCK_SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT_CYCLES  = 65535
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_csn,
  input  logic       spi_sclk,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic [2:0] target,
  output logic       data_strobe,
  output logic       data_start,
  output logic [7:0] data_out,
  input  logic [7:0] data_in,
  output logic       frame_active
);

  if (SCK_SYNC_STAGES < 2 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
    $error("mcu_spi_target: SCK_SYNC_STAGES must be >= 2 and TIMEOUT_CYCLES in 1..65535");
  end

  logic sck_rise, sck_fall, cs_rise, cs_fall, mosi_s;
  logic unused_sck_level, unused_cs_level, unused_mosi_rise, unused_mosi_fall;

  mcu_spi_sync #(.STAGES(SCK_SYNC_STAGES)) u_sync_sck (
    .clk   (clk),
    .reset (reset),
    .din   (spi_sclk),
    .level (unused_sck_level),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  // Chain resets low: CS held low through reset must not look like a new frame.
  mcu_spi_sync #(.STAGES(SCK_SYNC_STAGES)) u_sync_cs (
    .clk   (clk),
    .reset (reset),
    .din   (spi_csn),
    .level (unused_cs_level),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  mcu_spi_sync #(.STAGES(SCK_SYNC_STAGES)) u_sync_mosi (
    .clk   (clk),
    .reset (reset),
    .din   (spi_mosi),
    .level (mosi_s),
    .rise  (unused_mosi_rise),
    .fall  (unused_mosi_fall)
  );

  spi_state_t state;
  logic [2:0] bit_cnt;
  logic [7:0] rx_sr;
  logic [7:0] tx_sr;
  logic [7:0] rx_next;
  logic       payload_seen;

`ifdef MCU_SPI_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] idle_cnt;
`endif

  assign rx_next  = {rx_sr[6:0], mosi_s};
  assign spi_miso = tx_sr[7];

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      bit_cnt      <= '0;
      rx_sr        <= '0;
      tx_sr        <= '0;
      payload_seen <= 1'b0;
      target       <= TGT_SYSCTRL;
      data_strobe  <= 1'b0;
      data_start   <= 1'b0;
      data_out     <= '0;
      frame_active <= 1'b0;
`ifdef MCU_SPI_TIMEOUT_EN
      idle_cnt     <= '0;
`endif
    end else begin
      data_strobe <= 1'b0;
      data_start  <= 1'b0;
      // CS edges take priority over any coincident SCK edge.
      if (cs_rise) begin
        state        <= ST_IDLE;
        bit_cnt      <= '0;
        frame_active <= 1'b0;
      end else if (cs_fall && state == ST_IDLE) begin
        state        <= ST_TARGET;
        bit_cnt      <= '0;
        payload_seen <= 1'b0;
        tx_sr        <= '0;
        frame_active <= 1'b1;
`ifdef MCU_SPI_TIMEOUT_EN
        idle_cnt     <= '0;
`endif
      end else begin
        case (state)
          ST_TARGET, ST_PAYLOAD: begin
            if (sck_rise) begin
              rx_sr   <= rx_next;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (state == ST_TARGET) begin
                  target <= rx_next[2:0];
                  state  <= ST_PAYLOAD;
                end else begin
                  data_out     <= rx_next;
                  data_strobe  <= 1'b1;
                  data_start   <= ~payload_seen;
                  payload_seen <= 1'b1;
                end
              end
            end else if (sck_fall) begin
              if (bit_cnt != 3'd0) tx_sr <= {tx_sr[6:0], 1'b0};
              else                 tx_sr <= data_in;
            end
`ifdef MCU_SPI_TIMEOUT_EN
            if (sck_rise || sck_fall) begin
              idle_cnt <= '0;
            end else if (idle_cnt == TIMEOUT_LAST) begin
              state        <= ST_HOLD;
              bit_cnt      <= '0;
              frame_active <= 1'b0;
            end else begin
              idle_cnt <= idle_cnt + 16'd1;
            end
`endif
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mcu_spi_target.sv
// Bench for mcu_spi_target: directed frames plus randomized frames against a byte-level model.
module tb_mcu_spi_target;

  localparam int unsigned STAGES = 2;
  localparam int unsigned TO     = 100;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       spi_csn = 1'b1;
  logic       spi_sclk = 1'b0;
  logic       spi_mosi = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       spi_miso;
  logic [2:0] target;
  logic       data_strobe;
  logic       data_start;
  logic [7:0] data_out;
  logic       frame_active;

  always #5 clk = ~clk;

  mcu_spi_target #(
    .SCK_SYNC_STAGES (STAGES),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .spi_csn      (spi_csn),
    .spi_sclk     (spi_sclk),
    .spi_mosi     (spi_mosi),
    .spi_miso     (spi_miso),
    .target       (target),
    .data_strobe  (data_strobe),
    .data_start   (data_start),
    .data_out     (data_out),
    .data_in      (data_in),
    .frame_active (frame_active)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       s;
  } exp_t;

  int         tests = 0;
  int         fails = 0;
  exp_t       exp_q[$];
  logic [7:0] resp_q[$];
  logic [7:0] model_last = 8'h00;
  logic [2:0] model_target = 3'd0;
  int         strobe_count = 0;
  logic       last_start = 1'b0;
  int         half = 8;

  logic [7:0] fb[8];
  logic [7:0] fmiso[8];
  int         fn = 0;
  int         fpartial = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every strobe must match the next expected payload byte.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (data_strobe) begin
          exp_t e;
          strobe_count++;
          last_start = data_start;
          if (exp_q.size() == 0) begin
            check("unexpected_strobe", {31'd0, data_strobe}, 32'd0);
          end else begin
            e = exp_q.pop_front();
            model_last = e.d;
            check("strobe_start", {31'd0, data_start}, {31'd0, e.s});
            check("strobe_target", {29'd0, target}, {29'd0, model_target});
            check("strobe_frame_active", {31'd0, frame_active}, 32'd1);
          end
        end else begin
          check("start_without_strobe", {31'd0, data_start}, 32'd0);
        end
        check("data_out", {24'd0, data_out}, {24'd0, model_last});
      end
    end
  end

  // Responder: the selected target updates its response the cycle after each strobe.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && data_strobe) begin
        @(posedge clk);
        #1;
        if (resp_q.size() > 0) data_in = resp_q.pop_front();
        else                   data_in = 8'($urandom);
      end
    end
  end

  task automatic sck_bit(input logic b, output logic m);
    spi_mosi = b;
    repeat (half) @(negedge clk);
    m = spi_miso;
    spi_sclk = 1'b1;
    repeat (half) @(negedge clk);
    spi_sclk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] b, output logic [7:0] m);
    logic bm;
    for (int i = 7; i >= 0; i--) begin
      sck_bit(b[i], bm);
      m[i] = bm;
    end
  endtask

  task automatic frame_start();
    spi_csn = 1'b0;
    repeat (half) @(negedge clk);
  endtask

  task automatic frame_end();
    repeat (half) @(negedge clk);
    spi_csn = 1'b1;
    repeat (2 * half) @(negedge clk);
  endtask

  // MISO byte 0 is always 0x00; byte k carries the response present when byte k-1 ended.
  task automatic run_frame();
    logic [7:0] m;
    logic [7:0] exp_m;
    logic       bm;
    frame_start();
    for (int b = 0; b < fn; b++) begin
      exp_m = (b == 0) ? 8'h00 : data_in;
      if (b == 0) model_target = fb[0][2:0];
      else        exp_q.push_back('{d: fb[b], s: (b == 1)});
      spi_byte(fb[b], m);
      fmiso[b] = m;
      check("miso_byte", {24'd0, m}, {24'd0, exp_m});
    end
    for (int i = 0; i < fpartial; i++) sck_bit(1'($urandom), bm);
    frame_end();
    check("strobes_drained", exp_q.size(), 32'd0);
    check("target_after_frame", {29'd0, target}, {29'd0, model_target});
    check("frame_active_after", {31'd0, frame_active}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_miso"}, {31'd0, spi_miso}, 32'd0);
    check({tag, "_target"}, {29'd0, target}, 32'd0);
    check({tag, "_strobe"}, {31'd0, data_strobe}, 32'd0);
    check({tag, "_start"}, {31'd0, data_start}, 32'd0);
    check({tag, "_data_out"}, {24'd0, data_out}, 32'd0);
    check({tag, "_frame_active"}, {31'd0, frame_active}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    tests++;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    int   sc0;
    logic bm;

    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");

    // Plain frame with response path.
    half = 8;
    fn = 5;
    fb[0] = 8'h00; fb[1] = 8'h00; fb[2] = 8'hAA; fb[3] = 8'hBB; fb[4] = 8'hCC;
    resp_q.push_back(8'h5C); resp_q.push_back(8'h42); resp_q.push_back(8'h02);
    fpartial = 0;
    sc0 = strobe_count;
    run_frame();
    check("t1_strobes", strobe_count - sc0, 32'd4);
    check("t1_target", {29'd0, target}, 32'd0);
    check("t1_last_data", {24'd0, data_out}, 32'h0000_00CC);
    check("t1_miso0", {24'd0, fmiso[0]}, 32'h00);
    check("t1_miso1", {24'd0, fmiso[1]}, 32'h00);
    check("t1_miso2", {24'd0, fmiso[2]}, 32'h5C);
    check("t1_miso3", {24'd0, fmiso[3]}, 32'h42);
    check("t1_miso4", {24'd0, fmiso[4]}, 32'h02);

    // Abort after 5 payload bits, then a clean frame.
    fn = 1; fb[0] = 8'h01; fpartial = 5;
    sc0 = strobe_count;
    run_frame();
    check("abort_no_strobe", strobe_count - sc0, 32'd0);
    fn = 2; fb[0] = 8'h01; fb[1] = 8'h3C; fpartial = 0;
    run_frame();
    check("after_abort_strobes", strobe_count - sc0, 32'd1);
    check("after_abort_start", {31'd0, last_start}, 32'd1);
    check("after_abort_data", {24'd0, data_out}, 32'h3C);

    // Target select.
    fn = 2; fb[0] = 8'h02; fb[1] = 8'h10;
    sc0 = strobe_count;
    run_frame();
    check("tsel_target", {29'd0, target}, 32'd2);
    check("tsel_strobes", strobe_count - sc0, 32'd1);
    check("tsel_start", {31'd0, last_start}, 32'd1);
    check("tsel_data", {24'd0, data_out}, 32'h10);

    // Reset mid-byte with CS held low.
    frame_start();
    for (int i = 0; i < 4; i++) sck_bit(1'($urandom), bm);
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    model_last = 8'h00;
    model_target = 3'd0;
    @(negedge clk);
    reset = 1'b0;
    sc0 = strobe_count;
    for (int i = 0; i < 12; i++) sck_bit(1'($urandom), bm);
    repeat (half) @(negedge clk);
    check("rst_mid_strobes", strobe_count - sc0, 32'd0);
    check_reset_outputs("rst_mid");
    frame_end();

`ifdef MCU_SPI_TIMEOUT_EN
    // Watchdog: idle CS-low frame closes and ignores further clocks.
    spi_csn = 1'b0;
    repeat (TO + STAGES + 4) @(negedge clk);
    check("to_frame_active", {31'd0, frame_active}, 32'd0);
    sc0 = strobe_count;
    for (int i = 0; i < 16; i++) sck_bit(1'($urandom), bm);
    repeat (half) @(negedge clk);
    check("to_no_strobe", strobe_count - sc0, 32'd0);
    check("to_still_closed", {31'd0, frame_active}, 32'd0);
    frame_end();
`endif

    // Randomized frames.
    for (int f = 0; f < 16; f++) begin
      half = $urandom_range(10, 7);
      fn = $urandom_range(6, 1);
      for (int b = 0; b < 8; b++) fb[b] = 8'($urandom);
      fpartial = ($urandom_range(1, 0) == 1) ? $urandom_range(7, 1) : 0;
      sc0 = strobe_count;
      run_frame();
      check("rand_strobe_count", strobe_count - sc0, fn - 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mcu_spi_target.md
# mcu_spi_target

SPI target front end between the board MCU and the core-side control blocks. It oversamples the MCU's SPI lines in the `clk` domain and deserialises MOSI into bytes. The first byte of each chip-select frame is routed as a target select; every following byte is presented as a strobed byte with a start flag on the first one, which is exactly the byte stream `sysctrl`, the HID block and the OSD block consume. The response byte those blocks drive is serialised back on MISO.

## Interface
- `SCK_SYNC_STAGES`, default 2: synchronizer depth for `spi_csn`, `spi_sclk` and `spi_mosi`; minimum 2.
- `TIMEOUT_CYCLES`, default 65535: idle `clk` cycles with CS asserted before the frame is aborted. Used only with `MCU_SPI_TIMEOUT_EN`.
- `clk` in 1: system clock; all logic is on its rising edge.
- `reset` in 1: synchronous, active-high.
- `spi_csn` in 1: chip select, active-low, asynchronous to `clk`.
- `spi_sclk` in 1: SPI clock, mode 0 (CPOL=0, CPHA=0), MSB first, asynchronous.
- `spi_mosi` in 1: serial data from the MCU.
- `spi_miso` out 1: serial data to the MCU.
- `target` out 3: target-select byte `[2:0]` of the current frame. 0 = sysctrl, 1 = hid, 2 = osd, 3 = sdc.
- `data_strobe` out 1: one-cycle pulse when a payload byte is valid.
- `data_start` out 1: high together with `data_strobe` on the first payload byte of a frame.
- `data_out` out 8: received payload byte; stable from the strobe until the next strobe.
- `data_in` in 8: response byte from the selected target, muxed externally by `target`.
- `frame_active` out 1: high while a frame is open (synchronised CS low).

## Operation
- Synchronizers: `SCK_SYNC_STAGES` flops on each of CS, SCK and MOSI.
  - One extra registered copy of SCK and CS is used for edge detection.
  - Rising and falling SCK edges are one-cycle pulses.
- FSM states:
  - IDLE → TARGET on a CS falling edge. This clears the bit counter, clears the start flag and loads MISO shift register = `0x00`.
  - TARGET → PAYLOAD after 8 bits. `target` is updated and no strobe is issued.
  - PAYLOAD stays in PAYLOAD. Every 8 bits: `data_out` is loaded, `data_strobe` is pulsed, and `data_start` = 1 only on the first payload byte.
  - Any state → IDLE on CS rising edge.
- Bit capture: on an SCK rising pulse, shift register ← {sr[6:0], mosi_sync}; the 3-bit counter increments and wraps 7→0.
- MISO:
  - On an SCK falling pulse with counter ≠ 0, the shift register shifts left.
  - On an SCK falling pulse with counter == 0, tx ← `data_in`.
  - `spi_miso` = tx[7], registered.
- Partial byte at CS rise: discarded, no strobe.
- A CS edge coincident with an SCK edge: CS wins.
- `target` and `data_out` hold their values across IDLE.

## Timing
- Reset values: `spi_miso`=0, `target`=0, `data_strobe`=0, `data_start`=0, `data_out`=0x00, `frame_active`=0. FSM=IDLE, counter=0.
- Reset mid-frame: the frame is abandoned. The block stays IDLE until the next CS falling edge.
- Latency: the strobe asserts `SCK_SYNC_STAGES`+2 cycles after the 8th SCK rising edge at the pin.
- `data_in` must be valid by the SCK falling edge that ends the byte. Targets meet this by updating on the cycle after the strobe.
- SCK high time and SCK low time must each be ≥ `SCK_SYNC_STAGES`+2 `clk` periods. Nominally clk ≥ 8× SCK.
- MISO changes `SCK_SYNC_STAGES`+2 cycles after the falling pin edge. It is stable before the next rising edge.

## Configuration
- `MCU_SPI_TIMEOUT_EN` defined:
  - A 16-bit counter runs while CS is asserted and clears on every SCK edge.
  - At `TIMEOUT_CYCLES` the FSM forces IDLE, discards the partial byte and holds IDLE until CS deasserts and reasserts.
- `MCU_SPI_TIMEOUT_EN` undefined: the counter is absent, and a frame stays open indefinitely while CS is low.

## Structure
- Shared package `mcu_spi_pkg` holds:
  - the FSM state encoding (IDLE, TARGET, PAYLOAD, HOLD);
  - target constants `TGT_SYSCTRL`=0, `TGT_HID`=1, `TGT_OSD`=2, `TGT_SDC`=3.
- Sub-module `mcu_spi_sync`: parameterised N-stage synchronizer with edge-pulse outputs. It is instantiated for SCK and CS; MOSI uses the plain synchronised output.

## Test plan
- Frame CS↓, bytes 0x00, 0x00, 0xAA, 0xBB, 0xCC, CS↑:
  - `target`=0.
  - 4 strobes; `data_out` = 0x00 (start=1), then 0xAA, 0xBB, 0xCC (start=0).
- Response path: while in the frame above, `data_in` is driven to 0x5C, 0x42, 0x02 on the cycle after successive strobes. MISO bytes seen by the MCU are 0x00, 0x00, 0x5C, 0x42, 0x02.
- Abort: CS↑ after 5 bits of payload.
  - No strobe is issued.
  - The next frame starts cleanly, and its first byte carries start=1.
- Target select: frame with first byte 0x02, then 0x10. `target`=2, and exactly one strobe with start=1 and data 0x10.
- Reset: assert `reset` for 1 cycle mid-byte, then continue clocking SCK with CS held low. No strobes until CS↑/CS↓. All outputs match their reset values.
- With `MCU_SPI_TIMEOUT_EN` and `TIMEOUT_CYCLES`=100:
  - Hold CS low with SCK idle for 101 cycles: `frame_active`=0 and no strobe.
  - Further SCK pulses are ignored until CS is cycled.
